// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: bundles the icache, dcache and memory-side signals of the
// cache arbiter.
//   slave  : arbiter view. It samples client requests and memory returns, and
//            drives client responses and the memory request.
//   master : environment view. It drives the clients and the memory model.
// Signals:
//   i_read/i_addr, i_rdata/i_resp                     icache fill path
//   d_read/d_write/d_addr/d_wdata, d_rdata/d_resp     dcache fill/writeback path
//   mem_read/mem_write/mem_addr/mem_wdata, mem_rdata/mem_resp   memory side
interface cache_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one line-wide memory port between an icache (fills)
// and a dcache (fills and writebacks). One transaction is in flight at a time.
// Ties are broken round-robin, and icache wins the first tie after reset.
// Every output is driven straight from a register.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : cache_arbiter_if.slave (client request/response + memory port)
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  cache_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(5'b11111);

  // Line-align a byte address (32-byte lines).
  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
    return addr & ~OFFSET_MASK;
  endfunction

  state_t            state_r, state_nxt_s;
  logic              last_grant_r, last_grant_nxt_s;
  logic              mem_read_r, mem_read_nxt_s;
  logic              mem_write_r, mem_write_nxt_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt_s;
  logic [LINE_W-1:0] mem_wdata_r, mem_wdata_nxt_s;
  logic [LINE_W-1:0] i_rdata_r, i_rdata_nxt_s;
  logic [LINE_W-1:0] d_rdata_r, d_rdata_nxt_s;
  logic              i_resp_r, i_resp_nxt_s;
  logic              d_resp_r, d_resp_nxt_s;
  logic              i_pend_s, d_pend_s, grant_i_s, grant_d_s;

  // On a tie, icache wins only if dcache was granted last.
  assign i_pend_s  = bus.i_read;
  assign d_pend_s  = bus.d_read | bus.d_write;
  assign grant_i_s = i_pend_s & (~d_pend_s | (last_grant_r == GRANT_D));
  assign grant_d_s = d_pend_s & ~grant_i_s;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= GRANT_D;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      i_rdata_r    <= '0;
      d_rdata_r    <= '0;
      i_resp_r     <= 1'b0;
      d_resp_r     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      mem_read_r   <= mem_read_nxt_s;
      mem_write_r  <= mem_write_nxt_s;
      mem_addr_r   <= mem_addr_nxt_s;
      mem_wdata_r  <= mem_wdata_nxt_s;
      i_rdata_r    <= i_rdata_nxt_s;
      d_rdata_r    <= d_rdata_nxt_s;
      i_resp_r     <= i_resp_nxt_s;
      d_resp_r     <= d_resp_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_i_s) begin
          state_nxt_s = SERVE_I;
        end else if (grant_d_s) begin
          state_nxt_s = SERVE_D;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SERVE_I: begin
        if (bus.mem_resp) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = SERVE_I;
        end
      end
      SERVE_D: begin
        if (bus.mem_resp) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = SERVE_D;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs. Registers hold unless changed here.
  always_comb begin
    last_grant_nxt_s = last_grant_r;
    mem_read_nxt_s   = mem_read_r;
    mem_write_nxt_s  = mem_write_r;
    mem_addr_nxt_s   = mem_addr_r;
    mem_wdata_nxt_s  = mem_wdata_r;
    i_rdata_nxt_s    = i_rdata_r;
    d_rdata_nxt_s    = d_rdata_r;
    i_resp_nxt_s     = 1'b0;
    d_resp_nxt_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_i_s) begin
          last_grant_nxt_s = GRANT_I;
          mem_read_nxt_s   = 1'b1;
          mem_write_nxt_s  = 1'b0;
          mem_addr_nxt_s   = line_addr(bus.i_addr);
        end else if (grant_d_s) begin
          // A simultaneous read and write from dcache is a writeback.
          last_grant_nxt_s = GRANT_D;
          mem_read_nxt_s   = ~bus.d_write;
          mem_write_nxt_s  = bus.d_write;
          mem_addr_nxt_s   = line_addr(bus.d_addr);
          mem_wdata_nxt_s  = bus.d_wdata;
        end else begin
          mem_read_nxt_s   = 1'b0;
          mem_write_nxt_s  = 1'b0;
        end
      end
      SERVE_I: begin
        if (bus.mem_resp) begin
          mem_read_nxt_s  = 1'b0;
          mem_write_nxt_s = 1'b0;
          i_rdata_nxt_s   = bus.mem_rdata;
          i_resp_nxt_s    = 1'b1;
        end else begin
          i_resp_nxt_s    = 1'b0;
        end
      end
      SERVE_D: begin
        if (bus.mem_resp) begin
          mem_read_nxt_s  = 1'b0;
          mem_write_nxt_s = 1'b0;
          d_resp_nxt_s    = 1'b1;
          // A writeback returns no line, so d_rdata keeps its old value.
          if (!mem_write_r) begin
            d_rdata_nxt_s = bus.mem_rdata;
          end else begin
            d_rdata_nxt_s = d_rdata_r;
          end
        end else begin
          d_resp_nxt_s    = 1'b0;
        end
      end
      RESP: begin
        i_resp_nxt_s = 1'b0;
        d_resp_nxt_s = 1'b0;
      end
      default: begin
        mem_read_nxt_s  = 1'b0;
        mem_write_nxt_s = 1'b0;
      end
    endcase
  end

  assign bus.mem_read  = mem_read_r;
  assign bus.mem_write = mem_write_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.i_rdata   = i_rdata_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.i_resp    = i_resp_r;
  assign bus.d_resp    = d_resp_r;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: scoreboard bench for cache_arbiter. Each scenario pushes
// the transactions it expects the memory port to see, in the order the bench's
// round-robin model predicts. serve_one pops the next entry and checks it
// against the memory request. It then plays the memory and checks the
// response pulse and the rdata values.
module tb_cache_arbiter;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef struct {
    bit                is_d;
    bit                is_wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  txn_t              exp_q[$];
  int                total = 0;
  int                bad = 0;
  logic [LINE_W-1:0] m_i_rdata;
  logic [LINE_W-1:0] m_d_rdata;
  bit                hold_i = 1'b0;
  bit                hold_d = 1'b0;

  task automatic push_txn(input bit is_d, input bit is_wr, input logic [ADDR_W-1:0] addr,
                          input logic [LINE_W-1:0] wdata, input logic [LINE_W-1:0] rdata);
    txn_t t;
    t.is_d  = is_d;
    t.is_wr = is_wr;
    t.addr  = addr & 32'hFFFF_FFE0;
    t.wdata = wdata;
    t.rdata = rdata;
    exp_q.push_back(t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_i_rdata = '0;
    m_d_rdata = '0;
  endtask

  // Play memory for the next granted transaction: respond after lat cycles.
  task automatic serve_one(input int lat, output int hi_cycles, output int wait_cyc);
    txn_t t;
    bit   seen;
    seen      = 1'b0;
    wait_cyc  = 0;
    hi_cycles = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      wait_cyc++;
      if (bus.mem_read || bus.mem_write) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL serve_start: got no memory request in 20 cycles, required one");
      return;
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL serve_extra: got unexpected request addr=%h, required none", bus.mem_addr);
      return;
    end
    t = exp_q.pop_front();
    total++;
    if (bus.mem_addr !== t.addr) begin
      bad++;
      $display("FAIL mem_addr: got %h, required %h", bus.mem_addr, t.addr);
    end
    total++;
    if ({bus.mem_read, bus.mem_write} !== (t.is_wr ? 2'b01 : 2'b10)) begin
      bad++;
      $display("FAIL mem_op: got rd/wr=%b%b, required write=%0d", bus.mem_read, bus.mem_write, t.is_wr);
    end
    if (t.is_wr) begin
      total++;
      if (bus.mem_wdata !== t.wdata) begin
        bad++;
        $display("FAIL mem_wdata: got %h, required %h", bus.mem_wdata, t.wdata);
      end
    end
    hi_cycles = 1;
    repeat (lat) begin
      @(negedge clk);
      if (bus.mem_read || bus.mem_write) hi_cycles++;
      total++;
      if (bus.mem_addr !== t.addr) begin
        bad++;
        $display("FAIL mem_addr_stable: got %h, required %h", bus.mem_addr, t.addr);
      end
    end
    bus.mem_rdata = t.rdata;
    bus.mem_resp  = 1'b1;
    @(negedge clk);
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = {8{32'hDEAD_BEEF}};
    if (!t.is_d) m_i_rdata = t.rdata;
    else if (!t.is_wr) m_d_rdata = t.rdata;
    total++;
    if ({bus.i_resp, bus.d_resp} !== (t.is_d ? 2'b01 : 2'b10)) begin
      bad++;
      $display("FAIL resp: got i/d=%b%b, required dcache=%0d", bus.i_resp, bus.d_resp, t.is_d);
    end
    total++;
    if ((bus.mem_read | bus.mem_write) !== 1'b0) begin
      bad++;
      $display("FAIL mem_drop: got rd/wr=%b%b in resp cycle, required 00", bus.mem_read, bus.mem_write);
    end
    total++;
    if (bus.i_rdata !== m_i_rdata) begin
      bad++;
      $display("FAIL i_rdata: got %h, required %h", bus.i_rdata, m_i_rdata);
    end
    total++;
    if (bus.d_rdata !== m_d_rdata) begin
      bad++;
      $display("FAIL d_rdata: got %h, required %h", bus.d_rdata, m_d_rdata);
    end
    if (!t.is_d && !hold_i) bus.i_read = 1'b0;
    if (t.is_d && !hold_d) begin
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
    end
    @(negedge clk);
    total++;
    if ({bus.i_resp, bus.d_resp, bus.mem_read, bus.mem_write} !== 4'b0000) begin
      bad++;
      $display("FAIL idle_gap: got resp=%b%b rd/wr=%b%b after resp, required all 0",
               bus.i_resp, bus.d_resp, bus.mem_read, bus.mem_write);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp} !== 4'b0000 ||
        bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.i_rdata !== '0 || bus.d_rdata !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got nonzero outputs under reset, required all 0");
    end
  endtask

  task automatic test_read();
    int hi, wc;
    bus.i_read = 1'b1;
    bus.i_addr = 32'h0000_006C;
    push_txn(1'b0, 1'b0, 32'h0000_006C, '0, {32{8'hA5}});
    serve_one(3, hi, wc);
    total++;
    if (hi !== 4) begin
      bad++;
      $display("FAIL read_hold: got mem_read high %0d cycles, required 4", hi);
    end
  endtask

  task automatic test_write();
    int hi, wc;
    bus.d_write = 1'b1;
    bus.d_addr  = 32'h1000_0020;
    bus.d_wdata = {8{32'h1234_5678}};
    push_txn(1'b1, 1'b1, 32'h1000_0020, {8{32'h1234_5678}}, {32{8'h5A}});
    serve_one(1, hi, wc);
  endtask

  task automatic test_min_latency();
    int hi, wc;
    bus.i_read = 1'b1;
    bus.i_addr = 32'h0000_4A1F;
    push_txn(1'b0, 1'b0, 32'h0000_4A1F, '0, {8{32'h0BAD_F00D}});
    serve_one(0, hi, wc);
    total++;
    if (wc !== 1) begin
      bad++;
      $display("FAIL min_latency: got mem request %0d cycles after request, required 1", wc);
    end
  endtask

  task automatic test_rw_both();
    int hi, wc;
    bus.d_read  = 1'b1;
    bus.d_write = 1'b1;
    bus.d_addr  = 32'h2000_00FF;
    bus.d_wdata = {8{32'hCAFE_0001}};
    push_txn(1'b1, 1'b1, 32'h2000_00FF, {8{32'hCAFE_0001}}, {8{32'h7777_7777}});
    serve_one(2, hi, wc);
  endtask

  task automatic test_idle_resp();
    repeat (3) begin
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = {8{32'hFFFF_0000}};
      @(negedge clk);
      total++;
      if ({bus.i_resp, bus.d_resp, bus.mem_read, bus.mem_write} !== 4'b0000 ||
          bus.i_rdata !== m_i_rdata || bus.d_rdata !== m_d_rdata) begin
        bad++;
        $display("FAIL idle_resp: got outputs changed by mem_resp in IDLE, required unchanged");
      end
    end
    bus.mem_resp = 1'b0;
  endtask

  // Tie right after reset goes to icache. icache re-requests at once, which
  // makes a second tie, and dcache wins that one. icache is then served alone.
  task automatic test_tie();
    int hi, wc;
    do_reset();
    bus.i_addr  = 32'h0000_0100;
    bus.d_addr  = 32'h0000_0200;
    bus.i_read  = 1'b1;
    bus.d_read  = 1'b1;
    hold_i      = 1'b1;
    push_txn(1'b0, 1'b0, 32'h0000_0100, '0, {8{32'h1111_0001}});
    push_txn(1'b1, 1'b0, 32'h0000_0200, '0, {8{32'h2222_0002}});
    push_txn(1'b0, 1'b0, 32'h0000_0100, '0, {8{32'h1111_0003}});
    serve_one(1, hi, wc);
    serve_one(1, hi, wc);
    hold_i = 1'b0;
    serve_one(0, hi, wc);
  endtask

  task automatic test_alternate();
    int hi, wc;
    do_reset();
    bus.i_addr = 32'h0000_2044;
    bus.d_addr = 32'h0000_3088;
    bus.i_read = 1'b1;
    bus.d_read = 1'b1;
    hold_i     = 1'b1;
    hold_d     = 1'b1;
    for (int k = 0; k < 6; k++) begin
      push_txn(k[0], 1'b0, k[0] ? 32'h0000_3088 : 32'h0000_2044, '0, {8{32'hC0DE_0000 + k}});
    end
    for (int k = 0; k < 6; k++) begin
      if (k == 4) hold_i = 1'b0;
      if (k == 5) hold_d = 1'b0;
      serve_one(k % 3, hi, wc);
    end
  endtask

  task automatic test_reset_abort();
    int  hi, wc;
    bit  seen;
    seen = 1'b0;
    bus.d_read = 1'b1;
    bus.d_addr = 32'h0000_5040;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.mem_read) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL abort_start: got no SERVE_D request in 20 cycles, required one");
    end
    rst = 1'b1;
    #1;
    total++;
    if ({bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp} !== 4'b0000 ||
        bus.i_rdata !== '0 || bus.d_rdata !== '0 || bus.mem_addr !== '0) begin
      bad++;
      $display("FAIL abort_async: got nonzero outputs right after rst, required all 0");
    end
    bus.d_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_i_rdata = '0;
    m_d_rdata = '0;
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {8{32'h9999_9999}};
    @(negedge clk);
    bus.mem_resp = 1'b0;
    repeat (3) begin
      total++;
      if ({bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp} !== 4'b0000 ||
          bus.i_rdata !== '0 || bus.d_rdata !== '0) begin
        bad++;
        $display("FAIL abort_quiet: got resp=%b%b d_rdata=%h, required all 0",
                 bus.i_resp, bus.d_resp, bus.d_rdata);
      end
      @(negedge clk);
    end
    bus.i_read = 1'b1;
    bus.i_addr = 32'h0000_6060;
    push_txn(1'b0, 1'b0, 32'h0000_6060, '0, {8{32'h4242_4242}});
    serve_one(2, hi, wc);
  endtask

  initial begin
    rst           = 1'b1;
    bus.i_read    = 1'b0;
    bus.i_addr    = '0;
    bus.d_read    = 1'b0;
    bus.d_write   = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_resp  = 1'b0;
    m_i_rdata     = '0;
    m_d_rdata     = '0;
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_read();
    test_write();
    test_min_latency();
    test_rw_both();
    test_idle_resp();
    test_tie();
    test_alternate();
    test_reset_abort();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left: got %0d unserved entries, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 256, meaning cache line width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous and active-high.
REQ-005 SHALL have port i_read, input, 1, icache line-fill request.
REQ-006 SHALL have port i_addr, input, ADDR_W, icache line address.
REQ-007 SHALL have port i_rdata, output, LINE_W, line returned to icache.
REQ-008 SHALL have port i_resp, output, 1, icache completion pulse.
REQ-009 SHALL have port d_read, input, 1, dcache line-fill request.
REQ-010 SHALL have port d_write, input, 1, dcache writeback request.
REQ-011 SHALL have port d_addr, input, ADDR_W, dcache line address.
REQ-012 SHALL have port d_wdata, input, LINE_W, writeback line.
REQ-013 SHALL have port d_rdata, output, LINE_W, line returned to dcache.
REQ-014 SHALL have port d_resp, output, 1, dcache completion pulse.
REQ-015 SHALL have ports mem_read and mem_write, output, 1 each, single physical-memory (line adaptor) request.
REQ-016 SHALL have port mem_addr, output, ADDR_W, and port mem_wdata, output, LINE_W, toward memory.
REQ-017 SHALL have port mem_rdata, input, LINE_W, and port mem_resp, input, 1, from memory.

Function
REQ-018 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, RESP; all outputs registered.
REQ-019 IDLE: one requester pending -> grant it; both pending -> grant the one not granted last (round robin via last_grant flag).
REQ-020 Grant SHALL latch requester address with bits [4:0] forced to 0, latch d_wdata and op (write if d_write, else read); d_write&d_read together SHALL be treated as write.
REQ-021 Request sampled in IDLE at edge N SHALL drive mem_read/mem_write high from cycle N+1 (state SERVE_x); mem_addr/mem_wdata stable while in SERVE_x.
REQ-022 SERVE_x: mem_read/mem_write held until mem_resp=1; on that edge latch mem_rdata into the granted client's rdata register, drop mem_read/mem_write, enter RESP.
REQ-023 RESP: exactly one cycle of i_resp or d_resp (never both), rdata valid that cycle; next state IDLE; requests ignored in RESP.
REQ-024 Clients SHALL deassert request by the cycle after their resp pulse; arbiter need not detect violations.
REQ-025 Non-granted client's rdata SHALL hold its prior value; d_rdata SHALL not change on writebacks.
REQ-026 mem_resp while IDLE or RESP SHALL be ignored; mem_read and mem_write SHALL never be high together.
REQ-027 Minimum round trip: request at edge N, mem_resp at N+1 edge -> resp high in cycle N+2; back-to-back grants separated by ≥1 IDLE cycle.
REQ-028 last_grant SHALL update on every grant; a requester pending continuously SHALL be served within two transactions.

Reset
REQ-029 rst SHALL immediately force state IDLE, mem_read/mem_write/i_resp/d_resp=0, mem_addr/mem_wdata/i_rdata/d_rdata=0, last_grant=D (icache wins first tie).
REQ-030 rst during SERVE_x or RESP SHALL abort the transaction with no resp pulse; the in-flight mem_resp after deassertion is ignored.

Verification
REQ-031 i_read=1, i_addr=0x0000_006C; mem_resp after 3 cycles with rdata=0xA5..A5 -> mem_addr=0x0000_0060, mem_read high 4 cycles, one i_resp pulse with i_rdata=0xA5..A5.
REQ-032 d_write=1, d_addr=0x1000_0020, d_wdata=0x1234.. -> mem_write=1, mem_wdata=0x1234.., d_resp single pulse, d_rdata unchanged.
REQ-033 i_read and d_read raised same cycle after reset -> icache served first, then dcache; repeat tie -> dcache first.
REQ-034 Both requesters held continuously for 6 transactions -> grants alternate I,D,I,D,I,D.
REQ-035 rst asserted mid-SERVE_D, mem_resp arrives after rst released -> no resp pulse, all outputs 0, next i_read served normally.
REQ-036 d_read&d_write both 1 -> mem_write only; mem_resp in IDLE with no request -> no output change.
